// File: rtl/dec_seq_pkg.sv
// Shared encodings, state type and one-hot helper for the sequencing decoder.
// Optional feature macro: DEC_SEQ_BOUNCE_EN (ping-pong scan).
package dec_seq_pkg;

    localparam int MAX_NOUT = 16;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN,
        ST_SWEEP,
        ST_HOLD
    } state_t;

    // Widest vector; callers truncate to their NOUT.
    function automatic logic [MAX_NOUT-1:0] onehot_pol(
        input logic [3:0] idx,
        input logic       active_low
    );
        logic [MAX_NOUT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/dec_seq_nto2n_if.sv
// Control and output bundle of the sequencing decoder.
// Optional feature macro: DEC_SEQ_BOUNCE_EN (no effect on this bundle).
interface dec_seq_nto2n_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int NOUT = 2 ** SEL_W;

    logic               en_n;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic               load;
    logic [NOUT-1:0]    dout;
    logic [SEL_W-1:0]   idx;
    logic               busy;
    logic               wrap;

    modport master (
        output en_n, mode, sel, dwell, load,
        input  dout, idx, busy, wrap
    );

    modport slave (
        input  en_n, mode, sel, dwell, load,
        output dout, idx, busy, wrap
    );
endinterface

// File: rtl/dec_seq_dwell_cnt.sv
// Dwell counter: counts 0..dwell, terminal count compares the live dwell value.
// Optional feature macro: DEC_SEQ_BOUNCE_EN (no effect here).
module dec_seq_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               tc_o
);
    logic [DWELL_W-1:0] cnt_q;

    // >= so a dwell shrunk below the running count still ends this step
    assign tc_o = (cnt_q >= dwell_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/dec_seq_nto2n.sv
// Registered N-to-2^N decoder with direct, scan, sweep and hold modes.
// Optional feature macro: DEC_SEQ_BOUNCE_EN (ping-pong scan instead of wrap).
module dec_seq_nto2n
    import dec_seq_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dec_seq_nto2n_if.slave  bus
);
    localparam int               NOUT = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NOUT - 1);
    localparam logic [NOUT-1:0]  OFF  = {NOUT{ACTIVE_LOW != 0}};

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d, idx_step;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic [NOUT-1:0]  dout_q, dout_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic             step_wrap, scan_step;

    dec_seq_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .dwell_i (bus.dwell),
        .tc_o    (cnt_tc)
    );

`ifdef DEC_SEQ_BOUNCE_EN
    logic dn_q, dn_d, go_up;

    always_comb begin
        go_up     = dn_q ? (idx_q == '0) : (idx_q != LAST);
        idx_step  = go_up ? idx_q + 1'b1 : idx_q - 1'b1;
        step_wrap = (idx_step == LAST) || (idx_step == '0);
        dn_d      = (idx_step == LAST) ? 1'b1 :
                    (idx_step == '0)   ? 1'b0 : !go_up;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_q <= 1'b0;
        end else if (scan_step) begin
            dn_q <= dn_d;
        end
    end
`else
    assign idx_step  = idx_q + 1'b1;
    assign step_wrap = (idx_q == LAST);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        wrap_d    = 1'b0;
        dout_d    = dout_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        scan_step = 1'b0;
        if (bus.en_n) begin
            dout_d = OFF;
        end else begin
            unique case (bus.mode)
                MODE_DIRECT: begin
                    state_d = ST_DIRECT;
                    idx_d   = bus.sel;
                end
                MODE_SCAN: begin
                    state_d = ST_SCAN;
                    if (state_q != ST_SCAN) begin
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (cnt_tc) begin
                            scan_step = 1'b1;
                            idx_d     = idx_step;
                            wrap_d    = step_wrap;
                        end
                    end
                end
                MODE_SWEEP: begin
                    if (bus.load) begin
                        state_d = ST_SWEEP;
                        idx_d   = bus.sel;
                        cnt_clr = 1'b1;
                    end else if (state_q == ST_SWEEP) begin
                        cnt_en = 1'b1;
                        if (cnt_tc && idx_q == LAST) begin
                            state_d = ST_IDLE;
                            wrap_d  = 1'b1;
                        end else if (cnt_tc) begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                MODE_HOLD: begin
                    state_d = ST_HOLD;
                end
            endcase
            busy_d = (state_d == ST_SWEEP);
            // hold keeps whatever pattern was last driven
            if (state_d == ST_IDLE) begin
                dout_d = OFF;
            end else if (state_d != ST_HOLD) begin
                dout_d = NOUT'(onehot_pol(4'(idx_d), ACTIVE_LOW != 0));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            dout_q  <= OFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;
endmodule

// File: doc/dec_seq_nto2n.md
Name: dec_seq_nto2n

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It is the next generation of the team's 2-to-4 active-low decoder and adds configurable width, output polarity and an active-low enable. Besides direct decoding, it has two sequencing modes that step the active output autonomously: continuous scan and single sweep. It sits behind ui_in/uio_in in the tile top and drives uo_out for strobing LED/7-segment digit lines and row-select lines.

Parameters:
SEL_W, 2, select width; output count NOUT = 2**SEL_W (legal 1..4).
DWELL_W, 8, width of the dwell (cycles-per-step) field.
ACTIVE_LOW, 1, 1: selected output = 0 and others = 1; 0: one-hot high.

Ports:
clk  in  1  clock (single domain)
rst_n  in  1  asynchronous active-low reset
en_n  in  1  active-low enable; high forces all outputs inactive and freezes sequencing
mode  in  2  00 DIRECT, 01 SCAN, 10 SWEEP, 11 HOLD
sel  in  SEL_W  DIRECT select; SWEEP start index
dwell  in  DWELL_W  cycles per step = dwell+1
load  in  1  single-cycle pulse; starts a SWEEP
dout  out  NOUT  registered decoded outputs, polarity per ACTIVE_LOW
idx  out  SEL_W  current active index
busy  out  1  high while a SWEEP is in progress
wrap  out  1  one-cycle pulse when SCAN steps from NOUT-1 to 0, or when a SWEEP ends

Behaviour:
- Reset (async assert, sync release):
  - idx=0, dwell counter=0, busy=0, wrap=0, state=IDLE.
  - dout all inactive: all 1s if ACTIVE_LOW, else all 0s.
- Output function:
  - dout is registered: dout = polarity(onehot(idx_next)) when en_n=0 and state≠IDLE; otherwise all inactive.
  - Latency from sel to dout in DIRECT: 1 cycle.
- FSM states are IDLE, DIRECT, SCAN, SWEEP, HOLD. Mode is sampled every cycle; a change takes effect on the next edge.
  - IDLE: entered from reset. Leaves to the state named by mode. SWEEP is entered only on load=1.
  - DIRECT: idx<=sel every cycle.
  - SCAN: dwell counter counts 0..dwell. At terminal count: idx<=idx+1 mod NOUT, counter<=0. Step from NOUT-1 to 0 pulses wrap for 1 cycle. On entry, the counter clears and idx is kept.
  - SWEEP: on load, idx<=sel, busy<=1, counter<=0. Steps as in SCAN. After the dwell at idx=NOUT-1: busy<=0, wrap pulse, state<=IDLE, outputs go inactive. A load during SWEEP restarts the sweep from sel. With mode=10 and no load, the block stays in IDLE.
  - HOLD: idx and counter frozen; dout keeps its last value.
- en_n=1:
  - dout is inactive on the next edge.
  - idx, counter and state are frozen, and busy holds.
  - load is ignored.
  - Re-enabling resumes exactly where sequencing stopped.
- dwell=0: one step per cycle. dwell is sampled at each terminal-count compare, so a change applies from the current step onward.
- Leaving SWEEP via a mode change mid-sweep: busy<=0 with no wrap pulse.
- Simultaneous terminal step and load in SWEEP: load wins.
- Reset mid-sweep: all outputs return to reset values immediately (async).

Optional Feature:
DEC_SEQ_BOUNCE_EN
- Defined: SCAN ping-pongs 0→NOUT-1→0 instead of wrapping. A direction flag is added and reset to up. wrap pulses at each end reversal (idx reaching NOUT-1 or 0). SWEEP is unaffected.
- Undefined: modulo wrap as above. No direction flag is synthesised.

Decomposition:
- Package dec_seq_pkg holds:
  - the mode encodings MODE_DIRECT, MODE_SCAN, MODE_SWEEP, MODE_HOLD;
  - the state typedef state_t;
  - a function onehot_pol(idx, active_low) returning the NOUT-wide vector.
- One sub-module, dec_seq_dwell_cnt: the dwell counter with clear, enable, terminal-count output and sampled dwell compare.
- The FSM, idx register and output register live in the top.

Test Plan:
- Reset then DIRECT, ACTIVE_LOW=1, SEL_W=2, en_n=0, sel=2 → dout=4'b1011 one cycle later; idx=2; wrap=0.
- SCAN, dwell=3 → idx steps 0,1,2,3,0 every 4 cycles; wrap high for exactly 1 cycle on the 3→0 step; dout one-hot-low each step.
- SWEEP, sel=1, dwell=0, load pulse → busy=1 for 3 cycles; idx 1,2,3; then busy=0, wrap pulse, dout=4'b1111.
- SCAN running, en_n=1 for 5 cycles at idx=2 → dout=4'b1111 and idx held at 2; after en_n=0, counting resumes from the frozen counter value.
- rst_n asserted mid-SWEEP → dout=4'b1111, busy=0 and idx=0 without a clock edge. With DEC_SEQ_BOUNCE_EN and dwell=0: idx sequence 0,1,2,3,2,1,0,1 with wrap at 3 and 0.
